// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MD_MADD_EN to build the madd/maddu accumulate path (ops 6/7); otherwise those ops are ignored.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] numa,
    input  logic [WIDTH-1:0] numb,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW        = $clog2(MaxCycles + 1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV} mdState_t;

    mdState_t           stateQ, stateD;
    logic [CW-1:0]      cntQ, cntD;
    logic [2*WIDTH-1:0] pendQ, pendD;
    logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
`ifdef MD_MADD_EN
    logic               accQ, accD;
`endif

    logic [2*WIDTH-1:0] prodS, prodU;
    logic [WIDTH-1:0]   quo, rem;

    // Sign-extending to 2*WIDTH first makes the truncated unsigned product equal the signed one.
    assign prodS = {{WIDTH{numa[WIDTH-1]}}, numa} * {{WIDTH{numb[WIDTH-1]}}, numb};
    assign prodU = {{WIDTH{1'b0}}, numa} * {{WIDTH{1'b0}}, numb};

    always_comb begin
        quo = '1;
        rem = numa;
        if (numb == '0) begin
            quo = '1;
            rem = numa;
        end else if (!op[0] && numa == MinVal && numb == '1) begin
            quo = MinVal;
            rem = '0;
        end else if (!op[0]) begin
            quo = $signed(numa) / $signed(numb);
            rem = $signed(numa) % $signed(numb);
        end else begin
            quo = numa / numb;
            rem = numa % numb;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        pendD  = pendQ;
        hiD    = hiQ;
        loD    = loQ;
`ifdef MD_MADD_EN
        accD   = accQ;
`endif
        case (stateQ)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            pendD  = op[0] ? prodU : prodS;
                            cntD   = CW'(MULT_CYCLES);
                            stateD = MUL;
`ifdef MD_MADD_EN
                            accD   = 1'b0;
`endif
                        end
                        3'd2, 3'd3: begin
                            pendD  = {rem, quo};
                            cntD   = CW'(DIV_CYCLES);
                            stateD = DIV;
`ifdef MD_MADD_EN
                            accD   = 1'b0;
`endif
                        end
                        3'd4: hiD = numa;
                        3'd5: loD = numa;
                        default: begin
`ifdef MD_MADD_EN
                            pendD  = op[0] ? prodU : prodS;
                            cntD   = CW'(MULT_CYCLES);
                            stateD = MUL;
                            accD   = 1'b1;
`endif
                        end
                    endcase
                end
            end
            default: begin
                cntD = cntQ - CW'(1);
                if (cntQ == CW'(1)) begin
                    stateD = IDLE;
`ifdef MD_MADD_EN
                    {hiD, loD} = accQ ? ({hiQ, loQ} + pendQ) : pendQ;
`else
                    {hiD, loD} = pendQ;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            pendQ  <= '0;
            hiQ    <= '0;
            loQ    <= '0;
`ifdef MD_MADD_EN
            accQ   <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            pendQ  <= pendD;
            hiQ    <= hiD;
            loQ    <= loD;
`ifdef MD_MADD_EN
            accQ   <= accD;
`endif
        end
    end

    assign busy = (stateQ != IDLE);
    assign hi   = hiQ;
    assign lo   = loQ;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit with a behavioural HI/LO model.
// Expectations for ops 6/7 follow whether MD_MADD_EN is defined for the build.
module tb_md_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MD_MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] numa  = '0;
    logic [W-1:0] numb  = '0;
    logic         busy;
    logic [W-1:0] hi, lo;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .numa(numa), .numb(numb), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        int          cycles;
    } exp_t;

    exp_t        sbQ[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] refHi = '0;
    logic [31:0] refLo = '0;
    bit          abortPending = 1'b0;
    bit          prevBusy = 1'b0;
    int          busyCnt = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Monitor: every busy window must hold hi/lo, last the right length, and end on the queued result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy === 1'b1) begin
            busyCnt++;
            if (sbQ.size() > 0)
                checkOutput("hold", {hi, lo}, {sbQ[0].oldHi, sbQ[0].oldLo});
        end else if (prevBusy) begin
            if (abortPending) begin
                abortPending = 1'b0;
            end else if (sbQ.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", {hi, lo}, {e.expHi, e.expLo});
                checkOutput("busy_len", 64'(busyCnt), 64'(e.cycles));
            end
            busyCnt = 0;
        end
        prevBusy = (busy === 1'b1);
    end

    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0)
            checkOutput("timeout", {63'd0, busy}, 64'd0);
    endtask

    // Issue one op from idle at a negedge; the model decides whether it launches, writes directly, or is ignored.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb;
        int          ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ia = $signed(a);
        ib = $signed(b);
        start = 1'b1; op = o; numa = a; numb = b;
        e.oldHi = refHi; e.oldLo = refLo; e.cycles = 0;
        e.expHi = refHi; e.expLo = refLo;
        if (o == 3'd0 || o == 3'd6) p = sa * sb;
        else                        p = {32'd0, a} * {32'd0, b};
        if (o inside {3'd0, 3'd1} || (o inside {3'd6, 3'd7} && MaddEn)) begin
            if (o >= 3'd6) p = {refHi, refLo} + p;
            {e.expHi, e.expLo} = p;
            e.cycles = MC;
        end else if (o == 3'd2 || o == 3'd3) begin
            e.cycles = DC;
            if (b == 32'd0) begin
                e.expLo = 32'hFFFF_FFFF; e.expHi = a;
            end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.expLo = 32'h8000_0000; e.expHi = 32'd0;
            end else if (o == 3'd2) begin
                e.expLo = ia / ib; e.expHi = ia % ib;
            end else begin
                e.expLo = a / b; e.expHi = a % b;
            end
        end else if (o == 3'd4) begin
            refHi = a;
        end else if (o == 3'd5) begin
            refLo = a;
        end
        if (e.cycles > 0) begin
            sbQ.push_back(e);
            refHi = e.expHi;
            refLo = e.expLo;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (e.cycles > 0) begin
            if (inject) begin
                start = 1'b1; op = 3'd4; numa = 32'h0000_1234;
                @(negedge clk);
                start = 1'b0;
            end
            waitIdle();
        end else begin
            checkOutput("no_busy", {63'd0, busy}, 64'd0);
            checkOutput("direct", {hi, lo}, {refHi, refLo});
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        checkOutput("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        checkOutput("plan_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checkOutput("plan_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(3'd3, 32'd5, 32'd0, 1'b0);
        checkOutput("plan_divu0", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        applyStimulus(3'd4, 32'hAAAA_5555, 32'd0, 1'b0);
        applyStimulus(3'd5, 32'h1234_5678, 32'd0, 1'b0);
        checkOutput("plan_mthilo", {hi, lo}, 64'hAAAA_5555_1234_5678);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checkOutput("plan_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        applyStimulus(3'd0, 32'd3, 32'd4, 1'b0);
        applyStimulus(3'd6, 32'd2, 32'd5, 1'b0);
        checkOutput("plan_madd", {hi, lo}, MaddEn ? 64'h0000_0000_0000_0016 : 64'h0000_0000_0000_000C);

        start = 1'b1; op = 3'd2; numa = 32'd100; numb = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abortPending = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        refHi = '0;
        refLo = '0;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        repeat (DC + 3) @(negedge clk);
        checkOutput("abort_nolate", {hi, lo}, 64'd0);

        for (int i = 0; i < 60; i++)
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), ($urandom_range(0, 3) == 0));

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers for the five-stage pipelined CPU. It sits in the E stage beside the ALU and takes forwarded operands from the rse/rte bypass muxes. It runs multiply and divide over a configurable number of cycles and reports `busy` so hazard logic can stall mfhi/mflo and further md instructions. mthi/mtlo write HI/LO directly.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width (≥ 2)
- `MULT_CYCLES`, 5, busy cycles for mult/multu/madd/maddu (≥ 1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥ 1)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-low reset: sampled on the rising edge, 0 = reset
- `start`  in  1  launch the op on `op`; one-cycle pulse from the E-stage controller
- `op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu
- `numa`  in  WIDTH  rs operand (forwarded)
- `numb`  in  WIDTH  rt operand (forwarded)
- `busy`  out  1  operation in flight; registered
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, MUL, DIV. `busy` = (state != IDLE).
- IDLE, `start`=1:
  - ops 0/1/6/7: capture operands and compute the 2·WIDTH product (signed for 0/6, unsigned for 1/7) into a pending register; load counter = MULT_CYCLES; go to MUL.
  - ops 2/3: compute quotient and remainder (signed for 2, unsigned for 3) into pending; load counter = DIV_CYCLES; go to DIV.
  - op 4: hi ← numa. op 5: lo ← numa. State stays IDLE; `busy` stays 0.
- MUL/DIV: decrement the counter each cycle. When the counter reaches 1, at that edge:
  - {hi,lo} ← pending;
  - for madd/maddu, {hi,lo} ← {hi,lo} + pending instead, mod 2^(2·WIDTH);
  - return to IDLE.
- Mult result: hi = product[2W-1:W], lo = product[W-1:0].
- Div result: lo = quotient, hi = remainder. The remainder takes the sign of the dividend (truncating division).
- Divide by zero: lo = all ones, hi = numa. No exception.
- Signed overflow (MIN / −1): lo = MIN, hi = 0.
- `start` while busy: ignored entirely; mthi/mtlo included. Hazard logic must stall instead.
- `start` with op 6/7 when the macro is absent: ignored; no state change.
- Operands are captured only at the start edge. Changes on `numa`/`numb` during busy have no effect.

## Timing
- Reset (reset=0 at an edge): hi=0, lo=0, busy=0, state IDLE, counter 0. Reset wins over `start` and aborts an in-flight op; its pending result is discarded.
- Start at edge E0: `busy`=1 from E0 through the edge E0+N, where N = MULT_CYCLES or DIV_CYCLES. At edge E0+N, hi/lo update and `busy` falls together. hi/lo keep their old values until that edge.
- mthi/mtlo: hi/lo update at edge E0. Zero busy cycles.
- Back-to-back: a `start` in the cycle after `busy` falls is accepted. It uses the hi/lo just written, which matters for madd.
- Stall rule for the hazard unit: an md or mf instruction in D stalls while (`start` & op∈{0,1,2,3,6,7}) | `busy`.

## Configuration
- `MD_MADD_EN`: when defined, ops 6/7 (madd/maddu) accumulate the product into {hi,lo}. When undefined, the accumulate adder is not built and ops 6/7 are silently ignored.

## Test plan
- Signed mult: numa=FFFFFFFD, numb=5, op 0, start. `busy` is high for 5 cycles, then hi=FFFFFFFF, lo=FFFFFFF1.
- Unsigned mult: numa=FFFFFFFF, numb=2, op 1 → hi=00000001, lo=FFFFFFFE. A `start` (op 4, numa=1234) issued mid-busy is ignored; hi ends at 00000001.
- Signed div: numa=FFFFFFF9 (−7), numb=2, op 2. Busy for 10 cycles, then lo=FFFFFFFD, hi=FFFFFFFF. Next, divu 5/0 → lo=FFFFFFFF, hi=00000005.
- mthi/mtlo: op 4 numa=AAAA5555, then op 5 numa=12345678 on consecutive cycles. hi/lo update on the next edge each; busy never rises.
- Reset mid-div: drop reset low at cycle 4 of a div. Next cycle busy=0, hi=lo=0, and the pending result never appears.
- With `MD_MADD_EN`: mult 3×4 (lo=C), then madd 2×5 → hi=0, lo=16 (hex). Without the macro, the madd leaves lo=C and busy=0.
